// File: rtl/math_pkg.sv
// Shared definitions for the math library's sequential arithmetic blocks.
package math_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // Step counter must hold WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/integer_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module integer_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_cur,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_cur < divisor holds between steps, so a borrow always shows up
    // in the top bit of the WIDTH+1 bit difference.
    always_comb begin
        shifted  = {rem_cur, in_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/integer_divmod.sv
// Sequential signed/unsigned divider producing quotient and remainder with flags.
// Latency: WIDTH+1 edges from the accepting start edge to the done pulse.
// Backpressure: start is ignored while busy; no queueing.
module integer_divmod
    import math_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divider,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);

    localparam int               CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_PAT  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] num_q;   // dividend magnitude, shifts out as quotient shifts in
    logic [WIDTH-1:0] den_q;
    logic [WIDTH-1:0] prem_q;
    logic             q_neg;
    logic             r_neg;
    logic             zero_q;
    logic             ovf_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    always_comb begin
        a_neg = signed_mode & dividend[WIDTH-1];
        b_neg = signed_mode & divider[WIDTH-1];
        a_mag = a_neg ? -dividend : dividend;
        b_mag = b_neg ? -divider  : divider;
    end

    integer_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_cur  (prem_q),
        .in_bit   (num_q[WIDTH-1]),
        .divisor  (den_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            num_q     <= '0;
            den_q     <= '0;
            prem_q    <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_q  <= a_mag;
                        den_q  <= b_mag;
                        prem_q <= '0;
                        cnt    <= CNT_LOAD;
                        q_neg  <= a_neg ^ b_neg;
                        r_neg  <= a_neg;
                        zero_q <= (divider == '0);
                        ovf_q  <= signed_mode && (dividend == MIN_PAT) && (divider == '1);
                    end
                end
                CALC: begin
                    prem_q <= rem_next;
                    num_q  <= {num_q[WIDTH-2:0], q_bit};
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    // A zero divisor leaves |dividend| in the partial remainder,
                    // so the sign fix-up already restores the original dividend.
                    quotient  <= zero_q ? '1 : (q_neg ? -num_q : num_q);
                    remainder <= r_neg ? -prem_q : prem_q;
                    div_zero  <= zero_q;
                    overflow  <= ovf_q;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
